// File: rtl/clock_pkg.sv
// clock_pkg: shared state/select encodings, BCD limits and blank bit positions for the stopwatch controller
package clock_pkg;
  typedef enum logic [1:0] {ST_STOP = 2'd0, ST_RUN = 2'd1, ST_SET = 2'd2} state_t;
  typedef enum logic {SEL_SEC = 1'b0, SEL_MIN = 1'b1} sel_t;
  localparam logic [3:0] BCD_MAX9 = 4'd9;
  localparam logic [3:0] BCD_MAX5 = 4'd5;
  localparam int DEF_MIN_MAX = 29;
  localparam int DEF_BLINK_DIV = 50;
  localparam int BLK_C = 2;
  localparam int BLK_D = 3;
  localparam int BLK_E = 4;
  localparam int BLK_F = 5;
endpackage

// File: rtl/bcd_digit_cnt.sv
// bcd_digit_cnt: one BCD digit that wraps at i_max and flags a carry on the wrapping increment
module bcd_digit_cnt (
  input  logic       fs,
  input  logic       rst,
  input  logic       i_clr,
  input  logic       i_inc,
  input  logic [3:0] i_max,
  output logic [3:0] o_q,
  output logic       o_co
);
  logic [3:0] r_q;
  assign o_q  = r_q;
  assign o_co = i_inc && (r_q == i_max);
  always_ff @(posedge fs)
    if (rst || i_clr) r_q <= 4'd0;
    else if (i_inc) r_q <= o_co ? 4'd0 : r_q + 4'd1;
endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: STOP/RUN/SET stopwatch driving six BCD digits and a blink mask; LAP_HOLD_EN adds key_lap display freeze
module stopwatch_ctrl
  import clock_pkg::*;
#(
  parameter int MIN_MAX   = DEF_MIN_MAX,
  parameter int BLINK_DIV = DEF_BLINK_DIV
) (
  input  logic       fs,
  input  logic       rst,
  input  logic       tick,
  input  logic       key_start,
  input  logic       key_mode,
  input  logic       key_sel,
  input  logic       key_inc,
  input  logic       key_clr,
`ifdef LAP_HOLD_EN
  input  logic       key_lap,
`endif
  output logic [3:0] a,
  output logic [3:0] b,
  output logic [3:0] c,
  output logic [3:0] d,
  output logic [3:0] e,
  output logic [3:0] f,
  output logic [5:0] blank,
  output logic [1:0] state
);
  localparam int CW = $clog2(BLINK_DIV);
  localparam logic [CW-1:0] CNT_TOP = CW'(BLINK_DIV - 1);
  localparam logic [3:0] MIN_E = 4'(MIN_MAX % 10);
  localparam logic [3:0] MIN_F = 4'(MIN_MAX / 10);
  state_t r_state, w_state_n;
  sel_t r_sel, w_sel_n;
  logic [CW-1:0] r_cnt, w_cnt_n;
  logic r_phase, w_phase_n;
  logic [5:0] r_blank, w_blank_n;
  logic [3:0] r_e, r_f, w_a, w_b, w_c, w_d;
  logic w_stop, w_run, w_set, w_act_mode, w_act_start, w_act_clr, w_act_sel, w_act_inc;
  logic w_a_co, w_b_co, w_c_co, w_d_co, w_min_inc, w_min_wrap, w_ab_clr, w_keep, w_wrap;
  assign w_stop = r_state == ST_STOP;
  assign w_run  = r_state == ST_RUN;
  assign w_set  = r_state == ST_SET;
  // Priority resolution only considers keys that are meaningful in the current state
  assign w_act_mode  = key_mode && !w_run;
  assign w_act_start = key_start && !w_set && !(w_stop && key_mode);
  assign w_act_clr   = key_clr && w_stop && !key_mode && !key_start;
  assign w_act_sel   = key_sel && w_set && !key_mode;
  assign w_act_inc   = key_inc && w_set && !key_mode && !key_sel;
  assign w_ab_clr    = w_act_clr || w_set || w_act_mode;
  bcd_digit_cnt u_a (.fs(fs), .rst(rst), .i_clr(w_ab_clr), .i_inc(w_run && tick), .i_max(BCD_MAX9), .o_q(w_a), .o_co(w_a_co));
  bcd_digit_cnt u_b (.fs(fs), .rst(rst), .i_clr(w_ab_clr), .i_inc(w_a_co), .i_max(BCD_MAX9), .o_q(w_b), .o_co(w_b_co));
  bcd_digit_cnt u_c (.fs(fs), .rst(rst), .i_clr(w_act_clr), .i_inc(w_b_co || (w_act_inc && r_sel == SEL_SEC)), .i_max(BCD_MAX9), .o_q(w_c), .o_co(w_c_co));
  bcd_digit_cnt u_d (.fs(fs), .rst(rst), .i_clr(w_act_clr), .i_inc(w_c_co), .i_max(BCD_MAX5), .o_q(w_d), .o_co(w_d_co));
  // Seconds wrap in SET never reaches minutes: the d carry only counts while running
  assign w_min_inc  = (w_run && w_d_co) || (w_act_inc && r_sel == SEL_MIN);
  assign w_min_wrap = r_f == MIN_F && r_e == MIN_E;
  always_ff @(posedge fs)
    if (rst || w_act_clr) begin
      r_e <= 4'd0;
      r_f <= 4'd0;
    end else if (w_min_inc) begin
      r_e <= (w_min_wrap || r_e == BCD_MAX9) ? 4'd0 : r_e + 4'd1;
      r_f <= w_min_wrap ? 4'd0 : (r_e == BCD_MAX9) ? r_f + 4'd1 : r_f;
    end
  always_comb begin
    w_state_n = w_act_mode ? (w_stop ? ST_SET : ST_STOP) : w_act_start ? (w_stop ? ST_RUN : ST_STOP) : r_state;
    w_sel_n   = w_act_mode ? SEL_SEC : w_act_sel ? sel_t'(~r_sel) : r_sel;
    w_keep    = w_set && !w_act_mode && !w_act_sel && !w_act_inc;
    w_wrap    = r_cnt == CNT_TOP;
    w_cnt_n   = !w_keep ? '0 : tick ? (w_wrap ? '0 : r_cnt + CW'(1)) : r_cnt;
    w_phase_n = w_keep && (r_phase ^ (tick && w_wrap));
    w_blank_n = '0;
    w_blank_n[BLK_D:BLK_C] = {2{w_phase_n && w_sel_n == SEL_SEC}};
    w_blank_n[BLK_F:BLK_E] = {2{w_phase_n && w_sel_n == SEL_MIN}};
  end
  always_ff @(posedge fs)
    if (rst) begin
      r_state <= ST_STOP;
      r_sel   <= SEL_SEC;
      r_cnt   <= '0;
      r_phase <= 1'b0;
      r_blank <= '0;
    end else begin
      r_state <= w_state_n;
      r_sel   <= w_sel_n;
      r_cnt   <= w_cnt_n;
      r_phase <= w_phase_n;
      r_blank <= w_blank_n;
    end
  assign blank = r_blank;
  assign state = r_state;
`ifdef LAP_HOLD_EN
  logic r_hold;
  logic [23:0] r_snap;
  logic w_act_lap;
  assign w_act_lap = key_lap && w_run && !key_start;
  always_ff @(posedge fs)
    if (rst || w_state_n != ST_RUN) r_hold <= 1'b0;
    else if (w_act_lap) r_hold <= ~r_hold;
  always_ff @(posedge fs)
    if (w_act_lap && !r_hold) r_snap <= {r_f, r_e, w_d, w_c, w_b, w_a};
  assign {f, e, d, c, b, a} = r_hold ? r_snap : {r_f, r_e, w_d, w_c, w_b, w_a};
`else
  assign {f, e, d, c, b, a} = {r_f, r_e, w_d, w_c, w_b, w_a};
`endif
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed scoreboard bench for stopwatch_ctrl (LAP_HOLD_EN section when defined)
module tb_stopwatch_ctrl;
  localparam logic [5:0] K_START = 6'd1, K_MODE = 6'd2, K_SEL = 6'd4, K_INC = 6'd8, K_CLR = 6'd16, K_LAP = 6'd32;
  logic fs = 1'b0, rst = 1'b1, tick = 1'b0;
  logic [5:0] keys = '0;
  logic [3:0] a, b, c, d, e, f;
  logic [5:0] blank;
  logic [1:0] state;
  logic [31:0] exp_q[$];
  string tag_q[$];
  int checks = 0, errors = 0;
  always #5 fs = ~fs;
  stopwatch_ctrl dut (
    .fs(fs), .rst(rst), .tick(tick),
    .key_start(keys[0]), .key_mode(keys[1]), .key_sel(keys[2]), .key_inc(keys[3]), .key_clr(keys[4]),
`ifdef LAP_HOLD_EN
    .key_lap(keys[5]),
`endif
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .blank(blank), .state(state)
  );
  function automatic logic [23:0] dig(input int m, input int s, input int cs);
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(cs / 10), 4'(cs % 10)};
  endfunction
  task automatic push_exp(input string tg, input int m, input int s, input int cs, input logic [5:0] bl, input logic [1:0] st);
    exp_q.push_back({dig(m, s, cs), bl, st});
    tag_q.push_back(tg);
  endtask
  task automatic check();
    logic [31:0] ex, obs;
    string tg;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty");
      return;
    end
    ex = exp_q.pop_front();
    tg = tag_q.pop_front();
    obs = {f, e, d, c, b, a, blank, state};
    assert (obs === ex) else begin
      errors++;
      $error("FAIL %s observed fedcba=%h blank=%b state=%0d expected fedcba=%h blank=%b state=%0d",
             tg, obs[31:8], obs[7:2], obs[1:0], ex[31:8], ex[7:2], ex[1:0]);
    end
  endtask
  task automatic step(input logic [5:0] k, input logic t);
    keys = k;
    tick = t;
    @(posedge fs); #1;
    keys = '0;
    tick = 1'b0;
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      step('0, 1'b1);
      step('0, 1'b0);
    end
  endtask
  task automatic incs(input int n);
    for (int i = 0; i < n; i++) step(K_INC, 1'b0);
  endtask
  initial begin
    #1ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    push_exp("reset", 0, 0, 0, 6'b0, 2'd0);
    repeat (2) @(posedge fs);
    #1 rst = 1'b0;
    check();
    push_exp("start_run", 0, 0, 0, 6'b0, 2'd1); step(K_START, 1'b0); check();
    push_exp("run_100_ticks", 0, 1, 0, 6'b0, 2'd1); ticks(100); check();
    push_exp("stop_clr_prio", 0, 1, 0, 6'b0, 2'd0); step(K_START | K_CLR, 1'b0); check();
    push_exp("stop_tick_ignored", 0, 1, 0, 6'b0, 2'd0); ticks(3); check();
    push_exp("stop_clr", 0, 0, 0, 6'b0, 2'd0); step(K_CLR, 1'b0); check();
    push_exp("enter_set", 0, 0, 0, 6'b0, 2'd2); step(K_MODE, 1'b0); check();
    push_exp("set_sec_59", 0, 59, 0, 6'b0, 2'd2); incs(59); check();
    step(K_SEL, 1'b0);
    push_exp("set_min_1", 1, 59, 0, 6'b0, 2'd2); incs(1); check();
    push_exp("leave_set", 1, 59, 0, 6'b0, 2'd0); step(K_MODE, 1'b0); check();
    step(K_START, 1'b0);
    push_exp("run_to_2min", 2, 0, 0, 6'b0, 2'd1); ticks(100); check();
    step(K_START, 1'b0);
    step(K_CLR, 1'b0);
    step(K_MODE, 1'b0);
    push_exp("blink_on", 0, 0, 0, 6'b001100, 2'd2); ticks(50); check();
    push_exp("blink_off", 0, 0, 0, 6'b000000, 2'd2); ticks(50); check();
    push_exp("blink_on2", 0, 0, 0, 6'b001100, 2'd2); ticks(50); check();
    push_exp("inc_unblank", 0, 1, 0, 6'b0, 2'd2); step(K_INC, 1'b0); check();
    push_exp("sel_over_inc", 0, 1, 0, 6'b0, 2'd2); step(K_SEL | K_INC, 1'b0); check();
    push_exp("blink_min", 0, 1, 0, 6'b110000, 2'd2); ticks(50); check();
    push_exp("set_min_29", 29, 1, 0, 6'b0, 2'd2); incs(29); check();
    push_exp("min_wrap", 0, 1, 0, 6'b0, 2'd2); incs(1); check();
    incs(7);
    step(K_SEL, 1'b0);
    push_exp("sec_at_59", 7, 59, 0, 6'b0, 2'd2); incs(58); check();
    push_exp("sec_wrap_nocarry", 7, 0, 0, 6'b0, 2'd2); incs(1); check();
    step(K_SEL, 1'b0); incs(22);
    step(K_SEL, 1'b0); incs(59);
    step(K_MODE, 1'b0);
    step(K_START, 1'b0);
    push_exp("run_29_59_99", 29, 59, 99, 6'b0, 2'd1); ticks(99); check();
    push_exp("full_wrap", 0, 0, 0, 6'b0, 2'd1); ticks(1); check();
    push_exp("stop_with_tick", 0, 0, 1, 6'b0, 2'd0); step(K_START, 1'b1); check();
    step(K_CLR, 1'b0);
    push_exp("mode_over_start", 0, 0, 0, 6'b0, 2'd2); step(K_MODE | K_START, 1'b0); check();
    step(K_SEL, 1'b0); incs(5);
    step(K_SEL, 1'b0); incs(12);
    step(K_MODE, 1'b0);
    step(K_START, 1'b0);
    push_exp("run_05_12_34", 5, 12, 34, 6'b0, 2'd1); ticks(34); check();
    push_exp("run_keys_ignored", 5, 12, 34, 6'b0, 2'd1); step(K_CLR | K_MODE | K_SEL | K_INC, 1'b0); check();
    push_exp("rst_mid_run", 0, 0, 0, 6'b0, 2'd0);
    rst = 1'b1;
    step(K_START, 1'b1);
    rst = 1'b0;
    check();
`ifdef LAP_HOLD_EN
    step(K_START, 1'b0);
    ticks(100);
    push_exp("lap_freeze", 0, 1, 0, 6'b0, 2'd1); step(K_LAP, 1'b0); check();
    push_exp("lap_held", 0, 1, 0, 6'b0, 2'd1); ticks(50); check();
    push_exp("lap_release", 0, 1, 50, 6'b0, 2'd1); step(K_LAP, 1'b0); check();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
